// File: rtl/min_max_array_loader_pkg.sv
// -----------------------------------------------------------------------------
// min_max_array_loader_pkg
//
// Definitions shared by the array loader, its register file, the 16-entry
// min/max finder and their benches, so that every block agrees on the sample
// width, array depth and state encodings.
//
// Contents:
//   WIDTH, DEPTH, AW      sample width, number of entries, address width
//   loader_state_t        one-hot loader states FILL / STRT / WAIT
//   FINDER_*              one-hot state encodings of the min/max finder
// -----------------------------------------------------------------------------
package min_max_array_loader_pkg;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  // One-hot loader states; bit order matches {Qw,Qs,Qf}.
  typedef enum logic [2:0] {
    FILL = 3'b001,
    STRT = 3'b010,
    WAIT = 3'b100
  } loader_state_t;

  // One-hot states of the downstream min/max finder.
  localparam logic [3:0] FINDER_INI  = 4'b0001;
  localparam logic [3:0] FINDER_LOAD = 4'b0010;
  localparam logic [3:0] FINDER_COMP = 4'b0100;
  localparam logic [3:0] FINDER_DONE = 4'b1000;

endpackage

// File: rtl/min_max_array_loader_regs.sv
// -----------------------------------------------------------------------------
// min_max_array_loader_regs
//
// DEPTH x WIDTH register file with one synchronous write port and one
// asynchronous read port. Contents have no reset; an entry is X until it is
// first written.
//
// Ports:
//   Clk      in   clock, rising edge
//   wr_en    in   write enable
//   wr_addr  in   write address
//   wr_data  in   write data
//   rd_addr  in   read address
//   rd_data  out  mem[rd_addr], combinational
// -----------------------------------------------------------------------------
module min_max_array_loader_regs
  import min_max_array_loader_pkg::*;
#(
  parameter int W  = WIDTH,
  parameter int D  = DEPTH,
  parameter int AB = AW
) (
  input  logic          Clk,
  input  logic          wr_en,
  input  logic [AB-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [AB-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem [D];

  always_ff @(posedge Clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/min_max_array_loader.sv
// -----------------------------------------------------------------------------
// min_max_array_loader
//
// Upstream feeder for the 16-entry min/max finder. Samples arrive over a
// valid/ready handshake and are stored in a register array. Once the array is
// full the loader pulses Start for one cycle, then freezes the array until the
// finder reports Done, after which a new batch is accepted.
//
// Ports:
//   Clk       in   clock, rising edge
//   Reset     in   asynchronous, active-high reset
//   In_Data   in   sample to store
//   In_Valid  in   In_Data valid this cycle
//   In_Ready  out  loader accepts a sample this cycle (1 only in FILL)
//   Clear     in   synchronous discard of a partially filled batch
//   Start     out  one-cycle pulse; array is full and stable
//   Done      in   finder Done-state indicator, sampled each cycle
//   Rd_Addr   in   finder read address
//   Rd_Data   out  M[Rd_Addr], combinational
//   Count     out  entries written in the current batch, 0..DEPTH
//   Qf,Qs,Qw  out  one-hot state indicators for FILL, STRT, WAIT
// -----------------------------------------------------------------------------
module min_max_array_loader
  import min_max_array_loader_pkg::*;
#(
  parameter int W  = WIDTH,
  parameter int D  = DEPTH,
  parameter int AB = AW
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic [W-1:0]  In_Data,
  input  logic          In_Valid,
  output logic          In_Ready,
  input  logic          Clear,
  output logic          Start,
  input  logic          Done,
  input  logic [AB-1:0] Rd_Addr,
  output logic [W-1:0]  Rd_Data,
  output logic [AB:0]   Count,
  output logic          Qf,
  output logic          Qs,
  output logic          Qw
);

  // Count value at which the next handshake completes the batch.
  localparam logic [AB:0] LAST_COUNT = (AB+1)'(D - 1);

  loader_state_t state, next_state;
  logic [AB-1:0] ptr;
  logic [AB:0]   count;
  logic          wr_en;
  logic          batch_clr;

  // State register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= FILL;
    end else begin
      state <= next_state;
    end
  end

  // Next state and Moore outputs. Clear takes priority over a handshake in
  // FILL; any unexpected encoding falls back to FILL with an empty batch.
  always_comb begin
    next_state = state;
    wr_en      = 1'b0;
    batch_clr  = 1'b0;
    In_Ready   = 1'b0;
    Start      = 1'b0;
    case (state)
      FILL: begin
        In_Ready = 1'b1;
        if (Clear) begin
          batch_clr = 1'b1;
        end else if (In_Valid) begin
          wr_en = 1'b1;
          if (count == LAST_COUNT) begin
            next_state = STRT;
          end
        end
      end
      STRT: begin
        Start      = 1'b1;
        next_state = WAIT;
      end
      WAIT: begin
        if (Done) begin
          batch_clr  = 1'b1;
          next_state = FILL;
        end
      end
      default: begin
        batch_clr  = 1'b1;
        next_state = FILL;
      end
    endcase
  end

  // Write pointer and batch counter. The pointer is AW bits wide so it wraps
  // to 0 by itself after the last entry of a batch.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ptr   <= '0;
      count <= '0;
    end else if (batch_clr) begin
      ptr   <= '0;
      count <= '0;
    end else if (wr_en) begin
      ptr   <= ptr + 1'b1;
      count <= count + 1'b1;
    end
  end

  min_max_array_loader_regs #(
    .W  (W),
    .D  (D),
    .AB (AB)
  ) u_regs (
    .Clk     (Clk),
    .wr_en   (wr_en),
    .wr_addr (ptr),
    .wr_data (In_Data),
    .rd_addr (Rd_Addr),
    .rd_data (Rd_Data)
  );

  assign Count = count;
  assign Qf    = state[0];
  assign Qs    = state[1];
  assign Qw    = state[2];

endmodule
